fpu_mc_seq_ctrl: RTL and testbench

Parametrised sequencer for multicycle FPU operations such as divide and sqrt. It drives the operand-input select and the operand-register enable. It holds operands stable while the iterative unit runs, and adds a multi-cycle operand-load phase, abort, a latency watchdog, and registered completion/timeout pulses. It sits between the FPU top-level decode and the iterative arithmetic units.

---
 rtl/fpu_mc_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_fpu_mc_seq_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fpu_mc_seq_ctrl.sv
// Operand-load / wait sequencer for iterative FPU units (divide, sqrt).
// Optional completion counter enabled by defining FPU_MC_PERF_EN.
module fpu_mc_seq_ctrl #(
  parameter int              OP_W        = 5,
  parameter int              LOAD_CYCLES = 1,
  parameter int              MAX_LAT     = 32,
  parameter int              CNT_W       = 6,
  parameter logic [OP_W-1:0] MC_OP0      = 5'b00010,
  parameter logic [OP_W-1:0] MC_MASK0    = 5'b11110,
  parameter logic [OP_W-1:0] MC_OP1      = 5'b01011,
  parameter logic [OP_W-1:0] MC_MASK1    = 5'b11111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic            done,
  output logic            in_sel,
  output logic            reg_AB_en,
  output logic            busy,
  output logic            result_valid,
  output logic            timeout,
  output logic [15:0]     perf_mc_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             result_valid_q, result_valid_d;
  logic             timeout_q, timeout_d;
  logic             mc_op;

  assign mc_op = ((op & MC_MASK0) == (MC_OP0 & MC_MASK0)) |
                 ((op & MC_MASK1) == (MC_OP1 & MC_MASK1));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    result_valid_d = 1'b0;
    timeout_d      = 1'b0;
    in_sel         = 1'b1;
    reg_AB_en      = 1'b1;
    busy           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && mc_op) begin
          if (LOAD_CYCLES > 1) begin
            state_d = S_LOAD;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_LOAD: begin
        busy = 1'b1;
        if (!start) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LOAD_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        in_sel    = 1'b0;
        reg_AB_en = 1'b0;
        busy      = 1'b1;
        // Abort beats done, and done beats the watchdog on the same cycle.
        if (!start) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (done) begin
          state_d        = S_IDLE;
          cnt_d          = '0;
          result_valid_d = 1'b1;
        end else if (cnt_q == WAIT_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;

`ifdef FPU_MC_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (result_valid_d) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_mc_cnt = perf_q;
`else
  assign perf_mc_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fpu_mc_seq_ctrl.sv
// Randomised bench for fpu_mc_seq_ctrl against an operation-age reference model.
module tb_fpu_mc_seq_ctrl;

  localparam int LC = 3;
  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  op = 5'd0;
  logic        done = 1'b0;
  logic        in_sel, reg_AB_en, busy, result_valid, timeout;
  logic [15:0] perf_mc_cnt;

  int checks = 0;
  int failures = 0;

  // Model: an op is either absent or has an age counted in cycles since accept.
  bit          m_busy = 0;
  int          m_age = 0;
  bit          m_rv = 0;
  bit          m_to = 0;
  logic [15:0] m_perf = 16'd0;

  fpu_mc_seq_ctrl #(
    .OP_W(5), .LOAD_CYCLES(LC), .MAX_LAT(ML), .CNT_W(6),
    .MC_OP0(5'b00010), .MC_MASK0(5'b11110),
    .MC_OP1(5'b01011), .MC_MASK1(5'b11111)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .done(done),
    .in_sel(in_sel), .reg_AB_en(reg_AB_en), .busy(busy),
    .result_valid(result_valid), .timeout(timeout), .perf_mc_cnt(perf_mc_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit is_mc(input logic [4:0] o);
    return (o == 5'd2) || (o == 5'd3) || (o == 5'd11);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int w;
    if (reset) begin
      m_busy = 0; m_age = 0; m_rv = 0; m_to = 0; m_perf = 16'd0;
    end else begin
      m_rv = 0;
      m_to = 0;
      if (!m_busy) begin
        if (start && is_mc(op)) begin
          m_busy = 1;
          m_age  = 0;
        end
      end else if (m_age < LC - 1) begin
        if (!start) m_busy = 0;
        else m_age++;
      end else begin
        w = m_age - (LC - 1);
        if (!start) m_busy = 0;
        else if (done) begin
          m_busy = 0;
          m_rv   = 1;
`ifdef FPU_MC_PERF_EN
          m_perf = m_perf + 16'd1;
`endif
        end else if (w == ML - 1) begin
          m_busy = 0;
          m_to   = 1;
        end else m_age++;
      end
    end
  endtask

  task automatic step();
    bit exp_hold;
    @(posedge clk);
    model_edge();
    #1;
    exp_hold = m_busy && (m_age >= LC - 1);
    check("busy", 32'(busy), 32'(m_busy));
    check("in_sel", 32'(in_sel), 32'(!exp_hold));
    check("reg_AB_en", 32'(reg_AB_en), 32'(!exp_hold));
    check("result_valid", 32'(result_valid), 32'(m_rv));
    check("timeout", 32'(timeout), 32'(m_to));
    check("perf_mc_cnt", 32'(perf_mc_cnt), 32'(m_perf));
    $display("cyc t=%0t rst=%0b start=%0b op=%0d done=%0b busy=%0b en=%0b rv=%0b to=%0b perf=%0d",
             $time, reset, start, op, done, busy, reg_AB_en, result_valid, timeout, perf_mc_cnt);
  endtask

  task automatic drive(input bit r, input bit s, input logic [4:0] o, input bit d, input int n);
    reset = r; start = s; op = o; done = d;
    repeat (n) step();
  endtask

  initial begin
    logic [4:0] rop;
    // Reset with a pending multicycle request
    drive(1, 1, 5'b00010, 0, 2);
    drive(0, 0, 5'b00000, 0, 1);
    // Single-cycle op
    drive(0, 1, 5'b00000, 0, 5);
    // Divide: accept, load, 4 wait cycles, then done
    drive(0, 1, 5'b00011, 0, 1 + (LC - 1) + 4);
    drive(0, 1, 5'b00011, 1, 1);
    drive(0, 0, 5'b00011, 0, 2);
    // Abort on second WAIT cycle
    drive(0, 1, 5'b01011, 0, 1 + (LC - 1) + 1);
    drive(0, 0, 5'b01011, 0, 2);
    // Watchdog expiry
    drive(0, 1, 5'b00010, 0, 1 + (LC - 1) + ML + 1);
    drive(0, 0, 5'b00010, 0, 1);
    // done exactly on the watchdog limit
    drive(0, 1, 5'b00010, 0, 1 + (LC - 1) + (ML - 1));
    drive(0, 1, 5'b00010, 1, 1);
    drive(0, 0, 5'b00010, 0, 1);
    // Reset mid-op with done asserted
    drive(0, 1, 5'b00011, 0, 1 + (LC - 1) + 2);
    drive(1, 1, 5'b00011, 1, 1);
    drive(0, 0, 5'b00000, 0, 1);
    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: rop = 5'd2;
        1: rop = 5'd3;
        2: rop = 5'd11;
        default: begin
          rop = 5'($urandom());
        end
      endcase
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) != 0), rop,
            ($urandom_range(0, 7) == 0), 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
